// File: rtl/lab3_pkg.sv
// lab3_pkg: shared types and constants for the digit entry front end and the lock FSM
package lab3_pkg;
  typedef logic [3:0] digit_t;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} entry_state_t;
  localparam digit_t DIGIT_MAX = 4'd9;
  function automatic logic in_range(digit_t d);
    return d <= DIGIT_MAX;
  endfunction
endpackage

// File: rtl/digit_entry_if.sv
// digit_entry_if: digit stream (valid/ready plus error/overrun pulses); master = digit_entry, slave = consumer
interface digit_entry_if;
  import lab3_pkg::*;
  logic   digit_valid;
  logic   digit_ready;
  logic   digit_err;
  logic   overrun;
  digit_t digit;
  modport master(output digit_valid, digit, digit_err, overrun, input digit_ready);
  modport slave(input digit_valid, digit, digit_err, overrun, output digit_ready);
endinterface

// File: rtl/debounce_filter.sv
// debounce_filter: key synchronizer + debounce counter; ports clk, rst, i_key_n in; o_key (synced), o_level (debounced key_n), o_fall/o_rise strobes out
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_key,
  output logic o_level,
  output logic o_fall,
  output logic o_rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_mis;
  logic                   w_done;
  assign o_key   = r_sync[SYNC_STAGES-1];
  assign o_level = r_level;
  assign w_mis   = o_key != r_level;
  // level flips on the edge where the mismatch has persisted for DEBOUNCE_CYCLES samples
  assign w_done  = w_mis && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign o_fall  = w_done && !o_key;
  assign o_rise  = w_done && o_key;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '1;
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_key_n};
      r_cnt   <= (w_mis && !w_done) ? r_cnt + CW'(1) : '0;
      r_level <= w_done ? o_key : r_level;
    end
  end
endmodule

// File: rtl/digit_entry.sv
// digit_entry: one clean digit transfer per debounced press; ports clk, rst, key_n, sw in; pressed out; dig (master) digit stream; DIGIT_ENTRY_RANGE_CHECK_EN rejects sw>9 with digit_err
module digit_entry
  import lab3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   key_n,
  input  digit_t sw,
  output logic   pressed,
  digit_entry_if.master dig
);
  logic [SYNC_STAGES-1:0][3:0] r_sw;
  entry_state_t r_state, w_next;
  logic   w_key, w_level, w_fall, w_rise;
  logic   w_cap, w_bad, w_xfer, w_load, w_over;
  logic   r_valid, r_over;
  digit_t r_digit;
  digit_t w_sw;
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db (
    .clk(clk), .rst(rst), .i_key_n(key_n),
    .o_key(w_key), .o_level(w_level), .o_fall(w_fall), .o_rise(w_rise)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sw    <= '0;
    end else begin
      r_state <= w_next;
      r_sw    <= {r_sw[SYNC_STAGES-2:0], sw};
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:         w_next = w_key ? IDLE : PRESS_WAIT;
      PRESS_WAIT:   w_next = w_fall ? HELD : (w_key ? IDLE : PRESS_WAIT);
      HELD:         w_next = w_key ? RELEASE_WAIT : HELD;
      RELEASE_WAIT: w_next = w_rise ? IDLE : (w_key ? RELEASE_WAIT : HELD);
      default:      w_next = IDLE;
    endcase
  end
  assign w_sw   = r_sw[SYNC_STAGES-1];
  assign w_cap  = (r_state == PRESS_WAIT) && w_fall;
  assign w_xfer = r_valid && dig.digit_ready;
`ifdef DIGIT_ENTRY_RANGE_CHECK_EN
  logic r_err;
  assign w_bad = w_cap && !in_range(w_sw);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else r_err <= w_bad;
  end
  assign dig.digit_err = r_err;
`else
  assign w_bad = 1'b0;
  assign dig.digit_err = 1'b0;
`endif
  // a transfer on the capture edge frees the slot, so the new digit loads without overrun
  assign w_load = w_cap && !w_bad && (!r_valid || w_xfer);
  assign w_over = w_cap && !w_bad && r_valid && !w_xfer;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_digit <= '0;
      r_over  <= 1'b0;
    end else begin
      r_valid <= w_load || (r_valid && !w_xfer);
      r_digit <= w_load ? w_sw : r_digit;
      r_over  <= w_over;
    end
  end
  assign dig.digit_valid = r_valid;
  assign dig.digit       = r_digit;
  assign dig.overrun     = r_over;
  assign pressed         = !w_level;
endmodule
